// File: rtl/mmult_opt_mdc_ctrl_fsm_if.sv
// Handshake bundle between the mmult_opt_mdc controller and its streamers and engine.
// master = controller side, slave = streamer/engine side.
interface mmult_opt_mdc_ctrl_fsm_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 11
);
   logic [1:0]        src_ready;
   logic              sink_ready;
   logic [1:0]        src_done;
   logic              sink_done;
   logic              eng_ready;
   logic              eng_done;
   logic [1:0]        src_req_start;
   logic              sink_req_start;
   logic [ADDR_W-1:0] in1_addr;
   logic [ADDR_W-1:0] in2_addr;
   logic [ADDR_W-1:0] out_r_addr;
   logic              eng_start;
   logic              eng_enable;
   logic              eng_clear;
   logic [CNT_W-1:0]  eng_cnt_limit;

   modport master (
      input  src_ready, sink_ready, src_done, sink_done, eng_ready, eng_done,
      output src_req_start, sink_req_start, in1_addr, in2_addr, out_r_addr,
             eng_start, eng_enable, eng_clear, eng_cnt_limit
   );

   modport slave (
      output src_ready, sink_ready, src_done, sink_done, eng_ready, eng_done,
      input  src_req_start, sink_req_start, in1_addr, in2_addr, out_r_addr,
             eng_start, eng_enable, eng_clear, eng_cnt_limit
   );
endinterface

// File: rtl/mmult_opt_mdc_ctrl_fsm.sv
// Purpose: sequences in1/in2 sources, out_r sink and engine over nb_iter tiles; optional watchdog via MMULT_OPT_MDC_WATCHDOG_EN.
// Latency: all outputs registered one cycle behind the state; start_i->start pulses >=2 cycles, last done->done_o 2 cycles.
// Backpressure: START holds until both sources, the sink and the engine are ready; done pulses are held sticky until consumed.
module mmult_opt_mdc_ctrl_fsm #(
   parameter int CNT_W       = 11,
   parameter int ITER_W      = 16,
   parameter int ADDR_W      = 32,
   parameter int WDOG_CYCLES = 65535
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [ITER_W-1:0]     nb_iter_i,
   input  logic [ADDR_W-1:0]     in1_base_i,
   input  logic [ADDR_W-1:0]     in2_base_i,
   input  logic [ADDR_W-1:0]     out_r_base_i,
   input  logic [ADDR_W-1:0]     in1_stride_i,
   input  logic [ADDR_W-1:0]     in2_stride_i,
   input  logic [ADDR_W-1:0]     out_r_stride_i,
   input  logic [CNT_W-1:0]      cnt_limit_i,
   output logic [ITER_W-1:0]     iter_idx_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   mmult_opt_mdc_ctrl_fsm_if.master strm
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      COMPUTE,
      WAIT,
      UPDATEIDX,
      TERMINATE
   } state_t;

   state_t state_q, state_nxt;

   logic [ITER_W-1:0] nb_iter_q;
   logic [ITER_W-1:0] iter_idx_q;
   logic [ADDR_W-1:0] in1_stride_q, in2_stride_q, out_r_stride_q;
   logic [ADDR_W-1:0] in1_addr_q, in2_addr_q, out_r_addr_q;
   logic [CNT_W-1:0]  cnt_limit_q;

   logic [1:0] src_sticky_q;
   logic       sink_sticky_q;
   logic       eng_sticky_q;

   logic [1:0] src_req_q;
   logic       sink_req_q;
   logic       eng_start_q;
   logic       eng_enable_q;
   logic       eng_clear_q;
   logic       busy_q;
   logic       done_q;

   logic       accept, fire, upd;
   logic       all_rdy;
   logic [1:0] src_seen;
   logic       sink_seen, eng_seen;
   logic       in_run;
   logic [ITER_W:0] iter_inc;
   logic       last_tile;

   if (WDOG_CYCLES < 1) begin : g_wdog_chk
      $error("WDOG_CYCLES must be at least 1");
   end

   // A done pulse in the same cycle as the check counts as already captured.
   assign src_seen  = src_sticky_q | strm.src_done;
   assign sink_seen = sink_sticky_q | strm.sink_done;
   assign eng_seen  = eng_sticky_q | strm.eng_done;
   assign all_rdy   = (strm.src_ready == 2'b11) && strm.sink_ready && strm.eng_ready;
   assign in_run    = (state_q == COMPUTE) || (state_q == WAIT);
   assign iter_inc  = {1'b0, iter_idx_q} + (ITER_W+1)'(1);
   assign last_tile = !(iter_inc < {1'b0, nb_iter_q});

`ifdef MMULT_OPT_MDC_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
   logic [WDOG_W-1:0] wdog_cnt_q;
   logic              wdog_trip;
   logic              error_q;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      fire      = 1'b0;
      upd       = 1'b0;
`ifdef MMULT_OPT_MDC_WATCHDOG_EN
      wdog_trip = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (start_i) begin
               accept    = 1'b1;
               state_nxt = (nb_iter_i == '0) ? TERMINATE : START;
            end
         end
         START: begin
            if (all_rdy) begin
               fire      = 1'b1;
               state_nxt = COMPUTE;
            end
         end
         COMPUTE: begin
            if (eng_seen) state_nxt = WAIT;
         end
         WAIT: begin
            if ((&src_seen) && sink_seen) state_nxt = last_tile ? TERMINATE : UPDATEIDX;
         end
         UPDATEIDX: begin
            upd       = 1'b1;
            state_nxt = START;
         end
         TERMINATE: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
`ifdef MMULT_OPT_MDC_WATCHDOG_EN
      // Watchdog abort overrides any normal progress out of COMPUTE/WAIT.
      if (in_run && (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1))) begin
         wdog_trip = 1'b1;
         state_nxt = TERMINATE;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         nb_iter_q      <= '0;
         iter_idx_q     <= '0;
         in1_stride_q   <= '0;
         in2_stride_q   <= '0;
         out_r_stride_q <= '0;
         in1_addr_q     <= '0;
         in2_addr_q     <= '0;
         out_r_addr_q   <= '0;
         cnt_limit_q    <= '0;
         src_sticky_q   <= 2'b00;
         sink_sticky_q  <= 1'b0;
         eng_sticky_q   <= 1'b0;
         src_req_q      <= 2'b00;
         sink_req_q     <= 1'b0;
         eng_start_q    <= 1'b0;
         eng_enable_q   <= 1'b0;
         eng_clear_q    <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         src_req_q    <= fire ? 2'b11 : 2'b00;
         sink_req_q   <= fire;
         eng_start_q  <= fire;
         eng_enable_q <= in_run;
         eng_clear_q  <= upd || (state_q == TERMINATE);
         busy_q       <= (state_q != IDLE);
         done_q       <= (state_q == TERMINATE);

         if (accept) begin
            nb_iter_q      <= nb_iter_i;
            iter_idx_q     <= '0;
            in1_stride_q   <= in1_stride_i;
            in2_stride_q   <= in2_stride_i;
            out_r_stride_q <= out_r_stride_i;
            in1_addr_q     <= in1_base_i;
            in2_addr_q     <= in2_base_i;
            out_r_addr_q   <= out_r_base_i;
            cnt_limit_q    <= cnt_limit_i;
         end else if (upd) begin
            iter_idx_q   <= iter_idx_q + ITER_W'(1);
            in1_addr_q   <= in1_addr_q + in1_stride_q;
            in2_addr_q   <= in2_addr_q + in2_stride_q;
            out_r_addr_q <= out_r_addr_q + out_r_stride_q;
         end

         // Pulses seen in START are dropped: nothing can finish before it is started.
         if (accept || upd) begin
            src_sticky_q  <= 2'b00;
            sink_sticky_q <= 1'b0;
            eng_sticky_q  <= 1'b0;
         end else if (in_run) begin
            src_sticky_q  <= src_seen;
            sink_sticky_q <= sink_seen;
            eng_sticky_q  <= eng_seen;
         end
      end
   end

`ifdef MMULT_OPT_MDC_WATCHDOG_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wdog_cnt_q <= '0;
         error_q    <= 1'b0;
      end else begin
         if (fire)        wdog_cnt_q <= '0;
         else if (in_run) wdog_cnt_q <= wdog_cnt_q + WDOG_W'(1);
         if (accept)         error_q <= 1'b0;
         else if (wdog_trip) error_q <= 1'b1;
      end
   end
   assign error_o = error_q;
`else
   assign error_o = 1'b0;
`endif

   assign strm.src_req_start  = src_req_q;
   assign strm.sink_req_start = sink_req_q;
   assign strm.eng_start      = eng_start_q;
   assign strm.eng_enable     = eng_enable_q;
   assign strm.eng_clear      = eng_clear_q;
   assign strm.eng_cnt_limit  = cnt_limit_q;
   assign strm.in1_addr       = in1_addr_q;
   assign strm.in2_addr       = in2_addr_q;
   assign strm.out_r_addr     = out_r_addr_q;
   assign iter_idx_o          = iter_idx_q;
   assign busy_o              = busy_q;
   assign done_o              = done_q;

endmodule

// File: tb/tb_mmult_opt_mdc_ctrl_fsm.sv
// Randomized bench for mmult_opt_mdc_ctrl_fsm: reactive streamer/engine stubs plus a tile-level timing model.
module tb_mmult_opt_mdc_ctrl_fsm;
   localparam int CNT_W  = 11;
   localparam int ITER_W = 16;
   localparam int ADDR_W = 32;
`ifdef MMULT_OPT_MDC_WATCHDOG_EN
   localparam int WDOG = 100;
`else
   localparam int WDOG = 65535;
`endif

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic [ITER_W-1:0] nb_iter;
   logic [ADDR_W-1:0] b1, b2, b3, s1, s2, s3;
   logic [CNT_W-1:0]  lim;
   logic [ITER_W-1:0] iter_idx;
   logic busy, done, error;

   logic [ADDR_W-1:0] c_b1, c_b2, c_b3, c_s1, c_s2, c_s3;
   logic [CNT_W-1:0]  c_lim;

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;

   mmult_opt_mdc_ctrl_fsm_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) strm ();

   mmult_opt_mdc_ctrl_fsm #(
      .CNT_W(CNT_W), .ITER_W(ITER_W), .ADDR_W(ADDR_W), .WDOG_CYCLES(WDOG)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .nb_iter_i(nb_iter),
      .in1_base_i(b1), .in2_base_i(b2), .out_r_base_i(b3),
      .in1_stride_i(s1), .in2_stride_i(s2), .out_r_stride_i(s3),
      .cnt_limit_i(lim), .iter_idx_o(iter_idx), .busy_o(busy),
      .done_o(done), .error_o(error), .strm(strm)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic env_quiet();
      strm.src_ready  = 2'b11;
      strm.sink_ready = 1'b1;
      strm.eng_ready  = 1'b1;
      strm.src_done   = 2'b00;
      strm.sink_done  = 1'b0;
      strm.eng_done   = 1'b0;
   endtask

   task automatic scramble();
      nb_iter = ITER_W'($urandom);
      b1 = $urandom; b2 = $urandom; b3 = $urandom;
      s1 = $urandom; s2 = $urandom; s3 = $urandom;
      lim = CNT_W'($urandom);
   endtask

   task automatic new_cfg();
      c_b1 = $urandom; c_b2 = $urandom; c_b3 = $urandom;
      c_s1 = $urandom; c_s2 = $urandom; c_s3 = $urandom;
      c_lim = CNT_W'($urandom_range(1, 1024));
   endtask

   task automatic drive_start(input int n);
      start = 1'b1; nb_iter = ITER_W'(n);
      b1 = c_b1; b2 = c_b2; b3 = c_b3;
      s1 = c_s1; s2 = c_s2; s3 = c_s3;
      lim = c_lim;
   endtask

   // dmode 0: random delays; 1: eng +10, others +12; 2: sink and eng together at +5, sources +3
   task automatic pick_dly(input int dmode, output int de, output int d0, output int d1, output int dk);
      case (dmode)
         1: begin de = 10; d0 = 12; d1 = 12; dk = 12; end
         2: begin de = 5;  d0 = 3;  d1 = 3;  dk = 5;  end
         default: begin
            de = $urandom_range(1, 12); d0 = $urandom_range(1, 16);
            d1 = $urandom_range(1, 16); dk = $urandom_range(1, 16);
         end
      endcase
   endtask

   // rmode 0: always ready; 1: random readiness; 2: in2 source not ready for 5 cycles after start
   task automatic run_job(input int n, input int dmode, input int rmode);
      int t0, se, xb, xdone, xclr, tiles, clears, c, x;
      int te, ts0, ts1, tk, de, d0, d1, dk;
      bit fin, all_rdy;
      logic [ADDR_W-1:0] ea;
      step();
      t0 = cyc;
      drive_start(n);
      se = (n == 0) ? -1 : t0 + 1;
      xb = -1; xdone = (n == 0) ? t0 + 2 : -1; xclr = xdone;
      tiles = 0; clears = 0; fin = 0;
      te = -1; ts0 = -1; ts1 = -1; tk = -1;
      for (int k = 0; k < 4000 && !fin; k++) begin
         c = cyc;
         if (c != t0) begin start = 1'b0; scramble(); end
         strm.src_ready = 2'b11; strm.sink_ready = 1'b1; strm.eng_ready = 1'b1;
         if (rmode == 1) begin
            strm.src_ready  = 2'($urandom_range(0, 3));
            strm.sink_ready = 1'($urandom_range(0, 1));
            strm.eng_ready  = 1'($urandom_range(0, 1));
         end else if (rmode == 2 && c - t0 >= 1 && c - t0 <= 5) begin
            strm.src_ready = 2'b01;
         end
         strm.eng_done  = (c == te);
         strm.src_done  = {(c == ts1), (c == ts0)};
         strm.sink_done = (c == tk);
         all_rdy = (strm.src_ready == 2'b11) && strm.sink_ready && strm.eng_ready;
         if (se >= 0 && xb < 0 && c >= se && all_rdy) xb = c + 1;
         @(negedge clk);
         if ((strm.src_req_start != 2'b00) || strm.sink_req_start || strm.eng_start) begin
            check("burst_shape", {strm.src_req_start, strm.sink_req_start, strm.eng_start}, 4'b1111);
            check("burst_time", c, xb);
            check("burst_busy", busy, 1);
            ea = c_b1 + c_s1 * ADDR_W'(tiles); check("in1_addr", strm.in1_addr, ea);
            ea = c_b2 + c_s2 * ADDR_W'(tiles); check("in2_addr", strm.in2_addr, ea);
            ea = c_b3 + c_s3 * ADDR_W'(tiles); check("out_r_addr", strm.out_r_addr, ea);
            check("iter_idx", iter_idx, tiles);
            check("cnt_limit", strm.eng_cnt_limit, c_lim);
            pick_dly(dmode, de, d0, d1, dk);
            te = c + de; ts0 = c + d0; ts1 = c + d1; tk = c + dk;
            x = te + 1;
            if (ts0 > x) x = ts0;
            if (ts1 > x) x = ts1;
            if (tk > x) x = tk;
            tiles++; xb = -1; se = -1;
            if (tiles >= n) begin xdone = x + 2; xclr = x + 2; end
            else begin se = x + 2; xclr = x + 2; end
         end
         if (strm.eng_clear) begin
            check("clear_time", c, xclr);
            clears++;
         end
         if (done) begin
            check("done_time", c, xdone);
            check("done_busy", busy, 1);
            check("done_error", error, 0);
            fin = 1;
         end
         if (!fin) step();
      end
      check("done_seen", fin, 1);
      check("tile_count", tiles, n);
      check("clear_count", clears, (n == 0) ? 1 : n);
      step();
      strm.eng_done = 1'b0; strm.src_done = 2'b00; strm.sink_done = 1'b0;
      @(negedge clk);
      check("busy_after", busy, 0);
      check("done_after", done, 0);
   endtask

   task automatic reset_mid_job();
      bit seen;
      int bad;
      new_cfg();
      env_quiet();
      step();
      drive_start(2);
      step();
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (strm.eng_start) seen = 1;
         else step();
      end
      check("rst_burst_seen", seen, 1);
      step(); step();
      rst = 1'b1;
      step();
      @(negedge clk);
      check("rst_ctl", {busy, done, error, strm.src_req_start, strm.sink_req_start,
                        strm.eng_start, strm.eng_enable, strm.eng_clear}, 0);
      check("rst_addr", {strm.in1_addr, strm.in2_addr}, 0);
      check("rst_addr_out", strm.out_r_addr, 0);
      check("rst_idx_lim", {iter_idx, strm.eng_cnt_limit}, 0);
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 12; k++) begin
         step();
         strm.eng_done  = (k == 2);
         strm.src_done  = (k == 3) ? 2'b11 : 2'b00;
         strm.sink_done = (k == 3);
         @(negedge clk);
         if (done || busy || strm.eng_start) bad++;
      end
      check("no_activity_after_rst", bad, 0);
      env_quiet();
   endtask

`ifdef MMULT_OPT_MDC_WATCHDOG_EN
   task automatic wdog_job();
      int b, dc, err_lost;
      new_cfg();
      env_quiet();
      step();
      drive_start(1);
      step();
      start = 1'b0;
      b = -1;
      for (int k = 0; k < 20 && b < 0; k++) begin
         @(negedge clk);
         if (strm.eng_start) b = cyc;
         else step();
      end
      check("wdog_burst_seen", (b >= 0), 1);
      dc = -1;
      for (int k = 0; k < WDOG + 40 && dc < 0; k++) begin
         step();
         @(negedge clk);
         if (done) begin
            dc = cyc;
            check("wdog_error_at_done", error, 1);
         end
      end
      check("wdog_done_time", dc, b + WDOG + 1);
      err_lost = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         @(negedge clk);
         if (!error) err_lost++;
      end
      check("wdog_error_held", err_lost, 0);
   endtask
`endif

   initial begin
      rst = 1'b1;
      start = 1'b0;
      env_quiet();
      scramble();
      repeat (3) step();
      @(negedge clk);
      check("reset_ctl", {busy, done, error, strm.src_req_start, strm.sink_req_start,
                          strm.eng_start, strm.eng_enable, strm.eng_clear}, 0);
      check("reset_addr", {strm.in1_addr, strm.out_r_addr}, 0);
      check("reset_idx", iter_idx, 0);
      rst = 1'b0;

      c_b1 = 32'h1000; c_b2 = 32'h2000; c_b3 = 32'h3000;
      c_s1 = 32'h40;   c_s2 = 32'h80;   c_s3 = 32'h100;
      c_lim = 11'd16;
      run_job(1, 1, 0);
      run_job(3, 1, 0);
      run_job(0, 0, 0);
      run_job(2, 2, 2);

      c_b1 = 32'hFFFF_FFC0; c_s1 = 32'h40;
      c_b3 = 32'hFFFF_FF00; c_s3 = 32'hFFFF_FFF0;
      run_job(3, 0, 1);

      reset_mid_job();
      new_cfg();
      run_job(2, 0, 0);

`ifdef MMULT_OPT_MDC_WATCHDOG_EN
      wdog_job();
      new_cfg();
      run_job(1, 0, 0);
`endif

      for (int j = 0; j < 10; j++) begin
         new_cfg();
         run_job($urandom_range(0, 4), 0, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
